// File: rtl/sobel_pkg.sv
// sobel_pkg: constants and types shared by the Sobel pipeline blocks.
//   DEF_IMG_WIDTH / DEF_IMG_HEIGHT : default frame geometry
//   PIX_W                          : pixel width in bits
//   pad_state_e                    : border-pad FSM state encoding (3-bit)
package sobel_pkg;

  localparam int DEF_IMG_WIDTH  = 720;
  localparam int DEF_IMG_HEIGHT = 540;
  localparam int PIX_W          = 8;

  typedef enum logic [2:0] {
    S_TOP   = 3'd0,  // row 0
    S_LEFT  = 3'd1,  // column 0 of an interior row
    S_PASS  = 3'd2,  // interior pixel, copied from the gradient stream
    S_RIGHT = 3'd3,  // last column of an interior row
    S_BOT   = 3'd4   // last row
  } pad_state_e;

endpackage

// File: rtl/raster_counter.sv
// raster_counter: W x H raster position counter.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   adv          : advance one pixel this cycle
//   x, y         : current raster position
//   row_end      : x is the last column
//   frame_end    : x,y is the last pixel of the frame
module raster_counter #(
  parameter int W  = 720,
  parameter int H  = 540,
  parameter int XW = $clog2(W),
  parameter int YW = $clog2(H)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          row_end,
  output logic          frame_end
);

  localparam logic [XW-1:0] X_LAST = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_comb begin
    row_end   = (x_q == X_LAST);
    frame_end = row_end && (y_q == Y_LAST);
    x_d       = x_q;
    y_d       = y_q;
    if (adv) begin
      if (row_end) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/sobel_border_pad.sv
// sobel_border_pad: drains the interior Sobel gradient stream
// ((W-2)*(H-2) bytes per frame, raster order) and re-emits a full W x H
// frame with a one-pixel zero border.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   in_rd_en/in_dout/in_empty   : gradient FIFO (first-word-fall-through)
//   out_wr_en/out_din/out_full  : output FIFO push side
//   frame_done            : one-cycle pulse the cycle after the last write
module sobel_border_pad
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             clock,
  input  logic             reset,
  output logic             in_rd_en,
  input  logic [PIX_W-1:0] in_dout,
  input  logic             in_empty,
  output logic             out_wr_en,
  output logic [PIX_W-1:0] out_din,
  input  logic             out_full,
  output logic             frame_done
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  localparam logic [XW-1:0] X_PRE = XW'(IMG_WIDTH - 2);
  localparam logic [YW-1:0] Y_PRE = YW'(IMG_HEIGHT - 2);

  pad_state_e    state_q, state_d;
  logic          frame_done_q, frame_done_d;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          row_end, frame_end;

  // Position advances exactly on accepted writes, so it always names the
  // pixel the next write will carry.
  raster_counter #(
    .W (IMG_WIDTH),
    .H (IMG_HEIGHT),
    .XW(XW),
    .YW(YW)
  ) u_pos (
    .clock    (clock),
    .reset    (reset),
    .adv      (out_wr_en),
    .x        (x),
    .y        (y),
    .row_end  (row_end),
    .frame_end(frame_end)
  );

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    out_din      = '0;

    if (!reset) begin
      // Interior pixels need both a byte available and room downstream;
      // pop and push are tied so no byte is ever dropped or repeated.
      if (state_q == S_PASS) begin
        in_rd_en  = !in_empty && !out_full;
        out_wr_en = !in_empty && !out_full;
        out_din   = in_dout;
      end else begin
        out_wr_en = !out_full;
      end

      if (out_wr_en) begin
        unique case (state_q)
          S_TOP:   if (row_end) state_d = S_LEFT;
          S_LEFT:  state_d = S_PASS;
          S_PASS:  if (x == X_PRE) state_d = S_RIGHT;
          S_RIGHT: state_d = (y < Y_PRE) ? S_LEFT : S_BOT;
          S_BOT: begin
            if (frame_end) begin
              state_d      = S_TOP;
              frame_done_d = 1'b1;
            end
          end
          // Unreachable encodings write a zero and resynchronise at row 0.
          default: state_d = S_TOP;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_TOP;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_border_pad.sv
module tb_sobel_border_pad;

  localparam int W = 5;
  localparam int H = 4;

  logic clk;

  // Instance A: 5x4
  logic       reset_a, in_rd_en_a, in_empty_a, out_wr_en_a, out_full_a, frame_done_a;
  logic [7:0] in_dout_a, out_din_a;
  logic [7:0] mem_a [0:63];
  int         wr_a = 0;
  int         rd_a = 0;
  logic       hold_empty_a;

  assign in_empty_a = (rd_a >= wr_a) || hold_empty_a;
  assign in_dout_a  = mem_a[rd_a[5:0]];

  // Instance B: 3x3, one interior byte 0xAB
  logic       reset_b, in_rd_en_b, in_empty_b, out_wr_en_b, out_full_b, frame_done_b;
  logic [7:0] in_dout_b, out_din_b;
  int         rd_b = 0;

  assign in_empty_b = (rd_b != 0);
  assign in_dout_b  = (rd_b == 0) ? 8'hAB : 8'h00;
  assign out_full_b = 1'b0;

  sobel_border_pad #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut_a (
    .clock(clk), .reset(reset_a), .in_rd_en(in_rd_en_a), .in_dout(in_dout_a),
    .in_empty(in_empty_a), .out_wr_en(out_wr_en_a), .out_din(out_din_a),
    .out_full(out_full_a), .frame_done(frame_done_a));

  sobel_border_pad #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) dut_b (
    .clock(clk), .reset(reset_b), .in_rd_en(in_rd_en_b), .in_dout(in_dout_b),
    .in_empty(in_empty_b), .out_wr_en(out_wr_en_b), .out_din(out_din_b),
    .out_full(out_full_b), .frame_done(frame_done_b));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_en = 0;

  // model state: raster index within frame, next unread byte, pending pulse
  int mpos   = 0;
  int m_rd   = 0;
  bit exp_fd = 0;

  logic [7:0] log_a[$];
  int         wcyc_a[$];
  int         fdc_a[$];
  logic [7:0] log_b[$];
  int         nfd_b = 0;

  int frame2[40] = '{0,0,0,0,0,  0,1,2,3,0,    0,4,5,6,0,    0,0,0,0,0,
                     0,0,0,0,0,  0,7,8,9,0,    0,10,11,12,0, 0,0,0,0,0};

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_rd_en_a) rd_a <= rd_a + 1;
    if (in_rd_en_b) rd_b <= rd_b + 1;
  end

  // Compare process: outputs seen here are committed at the next rising edge.
  always @(negedge clk) begin : cmp
    int mx, my;
    bit border, ewr, erd, nfd;
    if (chk_en) begin
      chk("frame_done", int'(frame_done_a), int'(exp_fd));
      mx     = mpos % W;
      my     = mpos / W;
      border = (mx == 0) || (mx == W-1) || (my == 0) || (my == H-1);
      ewr    = !reset_a && !out_full_a && (border || !in_empty_a);
      erd    = ewr && !border;
      chk("out_wr_en", int'(out_wr_en_a), int'(ewr));
      chk("in_rd_en", int'(in_rd_en_a), int'(erd));
      if (reset_a) chk("out_din_in_reset", int'(out_din_a), 0);
      else if (ewr) chk("out_din", int'(out_din_a), border ? 0 : int'(mem_a[m_rd[5:0]]));
      if (out_wr_en_a) begin
        log_a.push_back(out_din_a);
        wcyc_a.push_back(cyc);
      end
      if (frame_done_a) fdc_a.push_back(cyc);
      nfd = 0;
      if (reset_a) mpos = 0;
      else if (ewr) begin
        if (erd) m_rd++;
        if (mpos == W*H-1) begin
          mpos = 0;
          nfd  = 1;
        end else mpos++;
      end
      exp_fd = nfd;
      if (out_wr_en_b) log_b.push_back(out_din_b);
      if (frame_done_b) nfd_b++;
    end
  end

  task automatic push_a(input int b);
    mem_a[wr_a[5:0]] = b[7:0];
    wr_a++;
  endtask

  task automatic wait_wr_a(input int target, input int budget, input string nm);
    int b;
    b = budget;
    while (log_a.size() < target && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    if (log_a.size() < target) chk({nm, "_timeout"}, log_a.size(), target);
  endtask

  task automatic reset_a_cycles(input int n);
    reset_a = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string nm, input int s0, input int f0, input int n,
                           input int span);
    if (log_a.size() < s0 + n) begin
      chk({nm, "_count"}, log_a.size() - s0, n);
      return;
    end
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_px%0d", nm, i), int'(log_a[s0+i]), frame2[i]);
    chk({nm, "_span"}, wcyc_a[s0+n-1] - wcyc_a[s0], span);
    chk({nm, "_fd_count"}, fdc_a.size() - f0, n / 20);
    for (int k = 0; k < n / 20; k++)
      if (fdc_a.size() > f0 + k)
        chk($sformatf("%s_fd%0d_cycle", nm, k), fdc_a[f0+k], wcyc_a[s0+20*k+19] + 1);
  endtask

  initial begin
    int s0, f0;
    int r6[7] = '{0,0,0,0,0,0,3};
    int eb[9] = '{0,0,0,0,'hAB,0,0,0,0};
    reset_a = 1; reset_b = 1; hold_empty_a = 0; out_full_a = 0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1;

    // s1: bytes 1..6, no stalls
    for (int i = 1; i <= 6; i++) push_a(i);
    s0 = log_a.size(); f0 = fdc_a.size();
    reset_a = 0;
    wait_wr_a(s0 + 20, 100, "s1");
    reset_a_cycles(2);
    chk_frame("s1", s0, f0, 20, 19);

    // s2: input empty for 3 cycles at (1,1)
    for (int i = 1; i <= 6; i++) push_a(i);
    s0 = log_a.size(); f0 = fdc_a.size();
    reset_a = 0;
    wait_wr_a(s0 + 6, 50, "s2a");
    hold_empty_a = 1;
    repeat (3) @(posedge clk);
    #1 hold_empty_a = 0;
    wait_wr_a(s0 + 20, 100, "s2b");
    reset_a_cycles(2);
    chk_frame("s2", s0, f0, 20, 22);

    // s3: output full 4 cycles in top border, then 4 cycles in the interior
    for (int i = 1; i <= 6; i++) push_a(i);
    s0 = log_a.size(); f0 = fdc_a.size();
    reset_a = 0;
    wait_wr_a(s0 + 2, 50, "s3a");
    out_full_a = 1;
    repeat (4) @(posedge clk);
    #1 out_full_a = 0;
    wait_wr_a(s0 + 7, 50, "s3b");
    out_full_a = 1;
    repeat (4) @(posedge clk);
    #1 out_full_a = 0;
    wait_wr_a(s0 + 20, 100, "s3c");
    reset_a_cycles(2);
    chk_frame("s3", s0, f0, 20, 27);

    // s5: two frames back to back
    for (int i = 1; i <= 12; i++) push_a(i);
    s0 = log_a.size(); f0 = fdc_a.size();
    reset_a = 0;
    wait_wr_a(s0 + 40, 200, "s5");
    reset_a_cycles(2);
    chk_frame("s5", s0, f0, 40, 39);

    // s6: reset after 8 writes; restart consumes the next unread byte
    for (int i = 1; i <= 12; i++) push_a(i);
    s0 = log_a.size();
    reset_a = 0;
    wait_wr_a(s0 + 8, 50, "s6a");
    reset_a_cycles(2);
    reset_a = 0;
    s0 = log_a.size();
    wait_wr_a(s0 + 7, 50, "s6b");
    reset_a = 1;
    if (log_a.size() >= s0 + 7)
      for (int i = 0; i < 7; i++) chk($sformatf("s6_px%0d", i), int'(log_a[s0+i]), r6[i]);
    chk("s6_total_pops", rd_a, 33);

    // s4: 3x3 with a single interior byte
    reset_b = 0;
    begin
      int b;
      b = 50;
      while (log_b.size() < 9 && b > 0) begin
        @(posedge clk); #1;
        b--;
      end
    end
    reset_b = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("s4_count", log_b.size(), 9);
    if (log_b.size() >= 9)
      for (int i = 0; i < 9; i++) chk($sformatf("s4_px%0d", i), int'(log_b[i]), eb[i]);
    chk("s4_pops", rd_b, 1);
    chk("s4_frame_done", nfd_b, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
